// File: rtl/aes_key_sched_ctrl.sv
// Sequencer for the 128-bit AES key expander.
// It loads a cipher key and captures the NR+1 round keys into a local store.
// The store is then read by round index, optionally in reverse order for decryption.
module aes_key_sched_ctrl #(
  parameter int NR = 10,
  parameter int IW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_vld,
  output logic          key_rdy,
  input  logic [127:0]  key,
  input  logic          abort,
  output logic          kld,
  output logic [127:0]  ek_key,
  input  logic [31:0]   ek_w0,
  input  logic [31:0]   ek_w1,
  input  logic [31:0]   ek_w2,
  input  logic [31:0]   ek_w3,
  output logic          busy,
  output logic          ready,
  input  logic          rk_req,
  input  logic [IW-1:0] rk_idx,
  input  logic          rk_rev,
  output logic          rk_vld,
  output logic [127:0]  rk,
  output logic          rk_err
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EXPAND,
    READY
  } state_t;

  localparam logic [IW-1:0] LAST = IW'(NR);

  state_t         state_q, state_d;
  logic [IW-1:0]  rnd_q, rnd_d;
  logic [127:0]   ek_key_q, ek_key_d;
  logic           rk_vld_q, rk_vld_d;
  logic           rk_err_q, rk_err_d;
  logic [127:0]   rk_q, rk_d;

  logic [127:0]   store_q [0:NR];
  logic           store_we;
  logic [IW-1:0]  rd_addr;

  // Control FSM: key handshake, expander load strobe and round counting.
  always_comb begin
    state_d  = state_q;
    rnd_d    = rnd_q;
    ek_key_d = ek_key_q;
    key_rdy  = 1'b0;
    kld      = 1'b0;
    busy     = 1'b0;
    ready    = 1'b0;
    store_we = 1'b0;
    case (state_q)
      IDLE: begin
        key_rdy = 1'b1;
        if (key_vld) begin
          state_d  = LOAD;
          ek_key_d = key;
        end
      end
      LOAD: begin
        kld   = 1'b1;
        busy  = 1'b1;
        rnd_d = '0;
        if (abort) begin
          state_d = IDLE;
        end else begin
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        busy = 1'b1;
        if (abort) begin
          state_d = IDLE;
        end else begin
          store_we = 1'b1;
          rnd_d    = rnd_q + 1'b1;
          if (rnd_q == LAST) begin
            state_d = READY;
          end
        end
      end
      READY: begin
        ready   = 1'b1;
        key_rdy = 1'b1;
        if (key_vld) begin
          state_d  = LOAD;
          ek_key_d = key;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read port: a request is served only while the full key set is valid.
  always_comb begin
    rk_vld_d = 1'b0;
    rk_err_d = 1'b0;
    rk_d     = rk_q;
    rd_addr  = rk_rev ? (LAST - rk_idx) : rk_idx;
    if (rk_req) begin
      if ((state_q == READY) && (rk_idx <= LAST)) begin
        rk_vld_d = 1'b1;
        rk_d     = store_q[rd_addr];
      end else begin
        rk_err_d = 1'b1;
      end
    end
  end

  // Control and read-response registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      rnd_q    <= '0;
      ek_key_q <= '0;
      rk_vld_q <= 1'b0;
      rk_err_q <= 1'b0;
      rk_q     <= '0;
    end else begin
      state_q  <= state_d;
      rnd_q    <= rnd_d;
      ek_key_q <= ek_key_d;
      rk_vld_q <= rk_vld_d;
      rk_err_q <= rk_err_d;
      rk_q     <= rk_d;
    end
  end

  // Round-key store is left uncleared by reset; ready=0 marks it stale.
  always_ff @(posedge clk) begin
    if (rst && store_we) begin
      store_q[rnd_q] <= {ek_w0, ek_w1, ek_w2, ek_w3};
    end
  end

  assign ek_key = ek_key_q;
  assign rk_vld = rk_vld_q;
  assign rk_err = rk_err_q;
  assign rk     = rk_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl.
// An AES-128 key expander model drives ek_w0..3.
// Expected round keys come from a full key expansion and FIPS-197 constants.
module tb_aes_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         key_vld = 1'b0;
  logic         key_rdy;
  logic [127:0] key = '0;
  logic         abort = 1'b0;
  logic         kld;
  logic [127:0] ek_key;
  logic [31:0]  ek_w0, ek_w1, ek_w2, ek_w3;
  logic         busy;
  logic         ready;
  logic         rk_req = 1'b0;
  logic [3:0]   rk_idx = '0;
  logic         rk_rev = 1'b0;
  logic         rk_vld;
  logic [127:0] rk;
  logic         rk_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0]   sbox_tab [0:255];
  logic [127:0] exp_key = '0;
  logic [127:0] exp_w   = '0;
  int           exp_rnd = 10;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;

  typedef struct {
    logic         req;
    logic [3:0]   idx;
    logic         rev;
    logic         vld;
    logic         err;
    logic [127:0] rk;
  } vec_t;

  vec_t vecs [17];

  aes_key_sched_ctrl #(.NR(10), .IW(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .key_vld (key_vld),
    .key_rdy (key_rdy),
    .key     (key),
    .abort   (abort),
    .kld     (kld),
    .ek_key  (ek_key),
    .ek_w0   (ek_w0),
    .ek_w1   (ek_w1),
    .ek_w2   (ek_w2),
    .ek_w3   (ek_w3),
    .busy    (busy),
    .ready   (ready),
    .rk_req  (rk_req),
    .rk_idx  (rk_idx),
    .rk_rev  (rk_rev),
    .rk_vld  (rk_vld),
    .rk      (rk),
    .rk_err  (rk_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in;
    b = b_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_rk(input logic [127:0] k, input int n);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    w[0] = k[127:96];
    w[1] = k[95:64];
    w[2] = k[63:32];
    w[3] = k[31:0];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
  endfunction

  function automatic vec_t mkVec(input logic req, input int idx, input logic rev,
                                 input logic vld, input logic err, input logic [127:0] r);
    vec_t v;
    v.req = req;
    v.idx = 4'(idx);
    v.rev = rev;
    v.vld = vld;
    v.err = err;
    v.rk  = r;
    return v;
  endfunction

  // Expander model: loads on kld and produces one round key per cycle afterwards.
  always @(posedge clk) begin
    if (kld) begin
      exp_key <= ek_key;
      exp_w   <= ek_key;
      exp_rnd <= 0;
    end else if (exp_rnd < 10) begin
      exp_w   <= ref_rk(exp_key, exp_rnd + 1);
      exp_rnd <= exp_rnd + 1;
    end
  end

  assign ek_w0 = exp_w[127:96];
  assign ek_w1 = exp_w[95:64];
  assign ek_w2 = exp_w[63:32];
  assign ek_w3 = exp_w[31:0];

  // Watchdog guards against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("[TB] FAIL %s: actual=%h required=%h", name, act, req);
  endtask

  task automatic checkBit(input string name, input logic act, input logic req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("[TB] FAIL %s: actual=%b required=%b", name, act, req);
  endtask

  task automatic checkInt(input string name, input int act, input int req);
    total_cnt++;
    if (act == req) pass_cnt++;
    else $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, req);
  endtask

  task automatic checkReset(input string tag);
    checkBit({tag, " key_rdy"}, key_rdy, 1'b1);
    checkBit({tag, " kld"}, kld, 1'b0);
    checkBit({tag, " busy"}, busy, 1'b0);
    checkBit({tag, " ready"}, ready, 1'b0);
    checkBit({tag, " rk_vld"}, rk_vld, 1'b0);
    checkBit({tag, " rk_err"}, rk_err, 1'b0);
    checkOutput({tag, " rk"}, rk, '0);
    checkOutput({tag, " ek_key"}, ek_key, '0);
  endtask

  task automatic acceptKey(input logic [127:0] k, input string tag);
    int n;
    n = 0;
    while (!key_rdy && n < 40) begin
      tick;
      n++;
    end
    checkBit({tag, " key_rdy before accept"}, key_rdy, 1'b1);
    key = k;
    key_vld = 1'b1;
    tick;
    key_vld = 1'b0;
    checkBit({tag, " kld after accept"}, kld, 1'b1);
    checkBit({tag, " busy after accept"}, busy, 1'b1);
    checkBit({tag, " ready after accept"}, ready, 1'b0);
  endtask

  task automatic waitReady(output int n);
    n = 0;
    while (!ready && n < 40) begin
      tick;
      n++;
    end
  endtask

  task automatic loadKey(input logic [127:0] k, input string tag);
    int n;
    acceptKey(k, tag);
    waitReady(n);
    checkInt({tag, " accept-to-ready cycles"}, n, 12);
    checkOutput({tag, " ek_key held"}, ek_key, k);
  endtask

  task automatic readKey(input int idx, input logic rev, input logic [127:0] k,
                         input logic rdy, input string tag);
    logic [127:0] req_rk;
    logic         ok;
    ok = rdy && (idx <= 10);
    req_rk = ok ? ref_rk(k, rev ? 10 - idx : idx) : rk;
    rk_req = 1'b1;
    rk_idx = 4'(idx);
    rk_rev = rev;
    tick;
    rk_req = 1'b0;
    checkBit($sformatf("%s idx%0d rev%0d rk_vld", tag, idx, rev), rk_vld, ok);
    checkBit($sformatf("%s idx%0d rev%0d rk_err", tag, idx, rev), rk_err, !ok);
    checkOutput($sformatf("%s idx%0d rev%0d rk", tag, idx, rev), rk, req_rk);
  endtask

  task automatic applyStimulus(input vec_t v);
    rk_req = v.req;
    rk_idx = v.idx;
    rk_rev = v.rev;
    tick;
    rk_req = 1'b0;
  endtask

  // Main test sequence.
  initial begin
    logic [127:0] k2, k3, k4, k5, prev_rk, req_rk;
    int n, bad;

    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, b;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      b = inv;
      sbox_tab[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end

    // Reset state.
    tick;
    tick;
    checkReset("reset");
    rst = 1'b1;
    readKey(0, 1'b0, '0, 1'b0, "idle read");

    // FIPS-197 key: latency and table-driven reads.
    loadKey(FIPS_KEY, "fips");
    vecs[0] = mkVec(1'b1, 0, 1'b0, 1'b1, 1'b0, FIPS_KEY);
    vecs[1] = mkVec(1'b1, 1, 1'b0, 1'b1, 1'b0, FIPS_RK1);
    for (int i = 2; i < 10; i++) vecs[i] = mkVec(1'b1, i, 1'b0, 1'b1, 1'b0, ref_rk(FIPS_KEY, i));
    vecs[10] = mkVec(1'b1, 10, 1'b0, 1'b1, 1'b0, FIPS_RK10);
    vecs[11] = mkVec(1'b1, 0, 1'b1, 1'b1, 1'b0, FIPS_RK10);
    vecs[12] = mkVec(1'b1, 10, 1'b1, 1'b1, 1'b0, FIPS_KEY);
    vecs[13] = mkVec(1'b1, 9, 1'b1, 1'b1, 1'b0, FIPS_RK1);
    vecs[14] = mkVec(1'b0, 3, 1'b0, 1'b0, 1'b0, '0);
    vecs[15] = mkVec(1'b1, 11, 1'b0, 1'b0, 1'b1, '0);
    vecs[16] = mkVec(1'b1, 15, 1'b1, 1'b0, 1'b1, '0);
    prev_rk = rk;
    for (int i = 0; i < 17; i++) begin
      req_rk = vecs[i].vld ? vecs[i].rk : prev_rk;
      applyStimulus(vecs[i]);
      checkBit($sformatf("vec%0d rk_vld", i), rk_vld, vecs[i].vld);
      checkBit($sformatf("vec%0d rk_err", i), rk_err, vecs[i].err);
      checkOutput($sformatf("vec%0d rk", i), rk, req_rk);
      prev_rk = req_rk;
    end

    // Abort during EXPAND, with a rejected read along the way.
    k2 = {$urandom, $urandom, $urandom, $urandom};
    acceptKey(k2, "abort");
    tick;
    readKey(5, 1'b0, k2, 1'b0, "read during expand");
    tick;
    tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checkBit("abort busy", busy, 1'b0);
    checkBit("abort ready", ready, 1'b0);
    checkBit("abort key_rdy", key_rdy, 1'b1);
    readKey(5, 1'b0, k2, 1'b0, "read after abort");
    loadKey(k2, "reload");
    for (int i = 0; i <= 10; i++) readKey(i, 1'($urandom_range(0, 1)), k2, 1'b1, "reload read");

    // Abort and key_vld together in LOAD: abort wins.
    k3 = {$urandom, $urandom, $urandom, $urandom};
    k4 = {$urandom, $urandom, $urandom, $urandom};
    acceptKey(k3, "abort+vld");
    abort = 1'b1;
    key = k4;
    key_vld = 1'b1;
    #1;
    checkBit("abort+vld key_rdy in LOAD", key_rdy, 1'b0);
    tick;
    abort = 1'b0;
    key_vld = 1'b0;
    checkBit("abort+vld busy", busy, 1'b0);
    checkBit("abort+vld ready", ready, 1'b0);
    checkOutput("abort+vld ek_key kept", ek_key, k3);

    // key_vld held through expansion; read on the same edge as the second accept.
    key = k3;
    key_vld = 1'b1;
    tick;
    key = k4;
    n = 0;
    bad = 0;
    while (!ready && n < 40) begin
      if (key_rdy) bad++;
      tick;
      n++;
    end
    checkInt("backpressure key_rdy high cycles", bad, 0);
    checkInt("backpressure accept-to-ready cycles", n, 12);
    checkOutput("backpressure ek_key before second accept", ek_key, k3);
    checkBit("backpressure key_rdy in READY", key_rdy, 1'b1);
    rk_req = 1'b1;
    rk_idx = 4'd3;
    rk_rev = 1'b0;
    tick;
    rk_req = 1'b0;
    key_vld = 1'b0;
    checkBit("old-key read rk_vld", rk_vld, 1'b1);
    checkOutput("old-key read rk", rk, ref_rk(k3, 3));
    checkBit("second accept ready fell", ready, 1'b0);
    checkBit("second accept kld", kld, 1'b1);
    checkOutput("second accept ek_key", ek_key, k4);
    readKey(3, 1'b0, k4, 1'b0, "read while reloading");
    waitReady(n);
    checkInt("second key remaining cycles", n, 11);
    for (int i = 0; i <= 10; i++) readKey(i, 1'b1, k4, 1'b1, "second key read");

    // Reset pulse in the middle of EXPAND.
    k5 = {$urandom, $urandom, $urandom, $urandom};
    acceptKey(k5, "mid-reset");
    for (int i = 0; i < 5; i++) tick;
    rst = 1'b0;
    tick;
    checkReset("mid-reset");
    rst = 1'b1;
    readKey(0, 1'b0, k5, 1'b0, "read after mid-reset");

    // Randomized keys and reads.
    for (int r = 0; r < 4; r++) begin
      logic [127:0] kr;
      kr = {$urandom, $urandom, $urandom, $urandom};
      loadKey(kr, $sformatf("rand%0d", r));
      for (int j = 0; j < 10; j++) begin
        readKey(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), kr, 1'b1,
                $sformatf("rand%0d", r));
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
